rom_bank_ctrl: RTL
==================

# rom_bank_ctrl

Parametrised, fully synchronous successor to the six-socket ROM board controller for the CPC expansion CPLD. Tracks the upper-ROM select port (&DFxx), maps up to 16 ROM slots (paired into 32K sockets) onto a run of consecutive ROM numbers from a software-programmable base, and asserts ROMDIS, socket chip-selects and ROM A14. The base is changed at run time through an unlock-protected configuration port (&DExx), so the firmware needs no DIP mode table.

## Interface
- NSLOT, 6, number of 16K slots; even, 2..16; socket k holds slots 2k (A14=0) and 2k+1 (A14=1)
- DEFAULT_BASE, 8'h01, ROM number of first upper slot after reset
- UNLOCK0, 8'h5A, first config-port unlock byte
- UNLOCK1, 8'hA5, second config-port unlock byte

- clk  in  1  CPC 4 MHz clock, all state on rising edge
- reset_b  in  1  asynchronous active-low reset
- adr  in  8  Z80 A[15:8]
- ioreq_b, wr_b  in  1  Z80 strobes
- romen_b  in  1  CPC ROMEN
- data  in  8  Z80 data bus
- dip_en  in  NSLOT  per-slot enable switches
- dip_lower  in  1  1 = slot 0 replaces the lower (firmware) ROM
- romdis  out  1  high when any slot is selected
- rom_cs_b  out  NSLOT/2  per-socket chip select, active low
- roma14  out  1  high when an odd slot is selected
- romoe_b  out  1  romen_b passed through combinationally
- base_q  out  8  current base ROM number (status)

## Operation
- Bus sample: on each clk, register {adr, ioreq_b, wr_b, data} into stage S1; S1 strobe state also copied to S2. qw = S1 ioreq_b low and S1 wr_b low. IO write event (iow) fires on the cycle qw=1 and the S2 copy had qw=0: exactly one event per IO cycle, data from S1.
- ROM select: iow with S1 adr==8'hDF → romsel_q <= S1 data.
- Config FSM, advanced only by iow with S1 adr==8'hDE:
  - LOCKED: data==UNLOCK0 → HALF; else stay.
  - HALF: data==UNLOCK1 → OPEN; else LOCKED.
  - OPEN: base_q <= data; → LOCKED.
  - Writes to other ports never change FSM state.
- Slot select cs[i] (combinational from registers and live adr[14]):
  - adr[14]=0: cs[0] = dip_lower & dip_en[0]; all others 0.
  - adr[14]=1, dip_lower=0: cs[i] = dip_en[i] & (romsel_q == base_q+i).
  - adr[14]=1, dip_lower=1: cs[0]=0; cs[i≥1] = dip_en[i] & (romsel_q == base_q+i-1).
  - base_q+i is 8-bit, modulo 256 (wraps); NSLOT<256 makes at most one cs active.
- Outputs: rom_cs_b[k] = !(cs[2k]|cs[2k+1]); roma14 = OR of odd cs; romdis = OR of all cs.

## Timing
- Reset (async, immediate): romsel_q=0, base_q=DEFAULT_BASE, FSM=LOCKED, S1/S2 strobes=1 (inactive). Outputs follow decode of those values; e.g. defaults with dip_lower=0, dip_en all 1, adr[14]=1 → no match (romsel 0 ≠ 1..6), romdis=0, rom_cs_b all 1, roma14=0.
- Latency: strobes low at pins before edge E → captured in S1 at E → romsel_q/base_q/FSM updated at E+1; outputs valid combinationally after E+1.
- Strobe must be seen high for ≥1 sampled cycle between writes; a write held low for many cycles counts once.
- Reset during HALF/OPEN returns to LOCKED; base_q restored to DEFAULT_BASE.
- adr[14] and romen_b paths are combinational; no clocked delay.

## Test plan
- Reset, dip_en=6'h3F, dip_lower=0; OUT &DF,3 → after E+1, adr[14]=1: cs[2] active, rom_cs_b=3'b101, roma14=0, romdis=1; OUT &DF,7 → romdis=0.
- Unlock: OUT &DE,5A; OUT &DE,A5; OUT &DE,FC → base_q=FC; OUT &DF,01 → slot 5 selected (FC+5=01 wrap), rom_cs_b=3'b011, roma14=1.
- Broken unlock: OUT &DE,5A; OUT &DE,00; OUT &DE,A5; OUT &DE,40 → base_q unchanged (01), FSM LOCKED.
- dip_lower=1, dip_en[0]=1: adr[14]=0 → cs[0], romdis=1, roma14=0; OUT &DF,01, adr[14]=1 → slot 1 selected (base+0), roma14=1; dip_en[1]=0 → romdis=0.
- Strobe held low 5 cycles on OUT &DE,5A then OUT &DE,A5 → FSM reaches OPEN (single event per cycle); assert reset_b low mid-OPEN → LOCKED, base_q=01, romsel_q=0 immediately.

Source files
------------

// File: rtl/rom_bank_ctrl.sv
// Upper-ROM bank controller: tracks &DFxx ROM select, maps NSLOT 16K slots onto
// consecutive ROM numbers from a base programmed through the unlocked &DExx port.
module rom_slot_dec #(
  parameter int IDX = 0
) (
  input  logic       a14,
  input  logic       dip_lower,
  input  logic       en,
  input  logic [7:0] romsel,
  input  logic [7:0] base,
  output logic       cs
);
  localparam logic IS0 = (IDX == 0);
  logic [7:0] rom_num;

  always_comb begin
    // With dip_lower set, slot 0 is the lower ROM and the upper run starts at slot 1.
    rom_num = base + 8'(IDX) - {7'd0, dip_lower};
    if (!a14)                 cs = IS0 & dip_lower & en;
    else if (IS0 && dip_lower) cs = 1'b0;
    else                      cs = en & (romsel == rom_num);
  end
endmodule

module rom_bank_ctrl #(
  parameter int         NSLOT        = 6,
  parameter logic [7:0] DEFAULT_BASE = 8'h01,
  parameter logic [7:0] UNLOCK0      = 8'h5A,
  parameter logic [7:0] UNLOCK1      = 8'hA5
) (
  input  logic               clk,
  input  logic               reset_b,
  input  logic [7:0]         adr,
  input  logic               ioreq_b,
  input  logic               wr_b,
  input  logic               romen_b,
  input  logic [7:0]         data,
  input  logic [NSLOT-1:0]   dip_en,
  input  logic               dip_lower,
  output logic               romdis,
  output logic [NSLOT/2-1:0] rom_cs_b,
  output logic               roma14,
  output logic               romoe_b,
  output logic [7:0]         base_q
);
  localparam logic [1:0] ST_LOCKED = 2'd0;
  localparam logic [1:0] ST_HALF   = 2'd1;
  localparam logic [1:0] ST_OPEN   = 2'd2;

  logic [7:0] adr_s1_q, data_s1_q;
  logic       ioreq_s1_q, wr_s1_q, ioreq_s2_q, wr_s2_q;
  logic [7:0] romsel_q, romsel_d, base_d;
  logic [1:0] st_q, st_d;
  logic       qw, qw_s2, iow;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      adr_s1_q   <= 8'd0;
      data_s1_q  <= 8'd0;
      ioreq_s1_q <= 1'b1;
      wr_s1_q    <= 1'b1;
      ioreq_s2_q <= 1'b1;
      wr_s2_q    <= 1'b1;
      romsel_q   <= 8'd0;
      base_q     <= DEFAULT_BASE;
      st_q       <= ST_LOCKED;
    end else begin
      adr_s1_q   <= adr;
      data_s1_q  <= data;
      ioreq_s1_q <= ioreq_b;
      wr_s1_q    <= wr_b;
      ioreq_s2_q <= ioreq_s1_q;
      wr_s2_q    <= wr_s1_q;
      romsel_q   <= romsel_d;
      base_q     <= base_d;
      st_q       <= st_d;
    end
  end

  // Rising edge of the sampled write qualifier: one event per IO cycle however long it lasts.
  assign qw    = ~ioreq_s1_q & ~wr_s1_q;
  assign qw_s2 = ~ioreq_s2_q & ~wr_s2_q;
  assign iow   = qw & ~qw_s2;

  always_comb begin
    romsel_d = romsel_q;
    base_d   = base_q;
    st_d     = st_q;
    if (iow && adr_s1_q == 8'hDF) romsel_d = data_s1_q;
    if (iow && adr_s1_q == 8'hDE) begin
      case (st_q)
        ST_LOCKED: st_d = (data_s1_q == UNLOCK0) ? ST_HALF : ST_LOCKED;
        ST_HALF:   st_d = (data_s1_q == UNLOCK1) ? ST_OPEN : ST_LOCKED;
        ST_OPEN: begin
          base_d = data_s1_q;
          st_d   = ST_LOCKED;
        end
        default:   st_d = ST_LOCKED;
      endcase
    end
  end

  // adr carries A[15:8], so A14 is adr[6].
  logic [NSLOT-1:0] cs;
  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    rom_slot_dec #(.IDX(i)) u_slot (
      .a14      (adr[6]),
      .dip_lower(dip_lower),
      .en       (dip_en[i]),
      .romsel   (romsel_q),
      .base     (base_q),
      .cs       (cs[i])
    );
  end

  for (genvar k = 0; k < NSLOT/2; k++) begin : g_sock
    assign rom_cs_b[k] = ~(cs[2*k] | cs[2*k+1]);
  end

  always_comb begin
    roma14 = 1'b0;
    for (int i = 1; i < NSLOT; i += 2) roma14 = roma14 | cs[i];
  end

  assign romdis  = |cs;
  assign romoe_b = romen_b;
endmodule
